// File: rtl/trace_sched_pkg.sv
// Shared state encoding, character constants and hex helper for the line-trace sequencer.
package trace_sched_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      FIELD = 3'd2,
      SEP   = 3'd3,
      EOL   = 3'd4
   } state_e;

   localparam logic [7:0] SEP_SP  = 8'h20;
   localparam logic [7:0] SEP_BAR = 8'h7C;
   localparam logic [7:0] COLON   = 8'h3A;
   localparam logic [7:0] NL      = 8'h0A;
   localparam logic [7:0] EMPTY   = 8'h00;

   // Header is four hex digits, a colon and a space.
   localparam logic [2:0] HDR_LAST_IDX = 3'd5;

   // Lowercase ASCII hex digit for one nibble.
   function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
      logic [7:0] ch;
      if (nib < 4'd10) begin
         ch = 8'h30 + {4'h0, nib};
      end else begin
         ch = 8'h57 + {4'h0, nib};
      end
      return ch;
   endfunction

endpackage

// File: rtl/trace_hdr_fmt.sv
// Header formatter: latches the 16-bit cycle stamp and walks out "hhhh: " one char at a time.
module trace_hdr_fmt
   import trace_sched_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] hdr_in,
   input  logic        advance,
   output logic [7:0]  hdr_char,
   output logic        done
);

   logic [15:0] hdr_q;
   logic [2:0]  cidx_q;

   // Latch the stamp on tick accept; step the char index on each header transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         hdr_q  <= 16'h0000;
         cidx_q <= 3'd0;
      end else if (load) begin
         hdr_q  <= hdr_in;
         cidx_q <= 3'd0;
      end else if (advance && !done) begin
         cidx_q <= cidx_q + 3'd1;
      end
   end

   // Present the char selected by the index; most significant digit first.
   always_comb begin
      hdr_char = SEP_SP;
      case (cidx_q)
         3'd0:    hdr_char = nibble_to_hex(hdr_q[15:12]);
         3'd1:    hdr_char = nibble_to_hex(hdr_q[11:8]);
         3'd2:    hdr_char = nibble_to_hex(hdr_q[7:4]);
         3'd3:    hdr_char = nibble_to_hex(hdr_q[3:0]);
         3'd4:    hdr_char = COLON;
         default: hdr_char = SEP_SP;
      endcase
   end

   assign done = (cidx_q == HDR_LAST_IDX);

endmodule

// File: rtl/trace_line_sched.sv
// Line-trace sequencer: header, requester fields separated by " | ", newline, on one byte stream.
module trace_line_sched
   import trace_sched_pkg::*;
#(
   parameter int unsigned p_nreqs     = 4,
   parameter int unsigned p_cnt_nbits = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick,
   output logic                   tick_rdy,
   input  logic [p_nreqs-1:0]     req_val,
   output logic [p_nreqs-1:0]     req_rdy,
   input  logic [8*p_nreqs-1:0]   req_char,
   input  logic [p_nreqs-1:0]     req_last,
   output logic                   out_val,
   input  logic                   out_rdy,
   output logic [7:0]             out_char,
   output logic [p_cnt_nbits-1:0] cycles,
   output logic [7:0]             drops,
   output logic                   busy
);

   localparam int unsigned idx_nbits = (p_nreqs > 1) ? $clog2(p_nreqs) : 1;
   localparam logic [idx_nbits-1:0] last_idx = idx_nbits'(p_nreqs - 1);

   state_e                 state_q;
   logic [idx_nbits-1:0]   idx_q;
   logic [1:0]             sep_cnt_q;
   logic [p_cnt_nbits-1:0] cycles_q;
   logic [7:0]             drops_q;
   logic                   tick_rdy_q;
   logic                   busy_q;

   logic       cur_val;
   logic       cur_last;
   logic [7:0] cur_char;
   logic       cur_empty;
   logic [7:0] hdr_char;
   logic       hdr_done;
   logic       hdr_adv;
   logic       tick_acc;
   logic       out_xfer;
   logic       field_take;

   trace_hdr_fmt u_hdr_fmt (
      .clk      (clk),
      .reset    (reset),
      .load     (tick_acc),
      .hdr_in   (cycles_q[15:0]),
      .advance  (hdr_adv),
      .hdr_char (hdr_char),
      .done     (hdr_done)
   );

   // Pick out the currently selected requester's val/char/last.
   always_comb begin
      cur_val  = 1'b0;
      cur_char = EMPTY;
      cur_last = 1'b0;
      for (int unsigned i = 0; i < p_nreqs; i++) begin
         if (idx_q == idx_nbits'(i)) begin
            cur_val  = req_val[i];
            cur_char = req_char[8*i +: 8];
            cur_last = req_last[i];
         end
      end
   end

   assign cur_empty = (cur_char == EMPTY);

   // Output mux; in FIELD the selected requester is passed straight through to the sink.
   always_comb begin
      out_val  = 1'b0;
      out_char = EMPTY;
      req_rdy  = '0;
      case (state_q)
         HDR: begin
            out_val  = 1'b1;
            out_char = hdr_char;
         end
         FIELD: begin
            // An empty-field char is swallowed here and never reaches the sink.
            out_val  = cur_val & ~cur_empty;
            out_char = cur_char;
            for (int unsigned i = 0; i < p_nreqs; i++) begin
               if (idx_q == idx_nbits'(i)) begin
                  req_rdy[i] = out_rdy | cur_empty;
               end
            end
         end
         SEP: begin
            out_val  = 1'b1;
            out_char = (sep_cnt_q == 2'd1) ? SEP_BAR : SEP_SP;
         end
         EOL: begin
            out_val  = 1'b1;
            out_char = NL;
         end
         default: begin
            out_val  = 1'b0;
         end
      endcase
   end

   assign tick_acc   = tick & tick_rdy_q;
   assign out_xfer   = out_val & out_rdy;
   assign hdr_adv    = (state_q == HDR) & out_xfer;
   assign field_take = (state_q == FIELD) & cur_val & (out_rdy | cur_empty);

   // Line sequencing FSM with field index, separator position, cycle counter and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         sep_cnt_q  <= 2'd0;
         cycles_q   <= '0;
         tick_rdy_q <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (tick_acc) begin
                  state_q    <= HDR;
                  cycles_q   <= cycles_q + p_cnt_nbits'(1);
                  tick_rdy_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            HDR: begin
               if (out_xfer && hdr_done) begin
                  state_q <= FIELD;
                  idx_q   <= '0;
               end
            end
            FIELD: begin
               if (field_take && cur_last) begin
                  if (idx_q == last_idx) begin
                     state_q <= EOL;
                  end else begin
                     state_q   <= SEP;
                     idx_q     <= idx_q + idx_nbits'(1);
                     sep_cnt_q <= 2'd0;
                  end
               end
            end
            SEP: begin
               if (out_xfer) begin
                  if (sep_cnt_q == 2'd2) begin
                     state_q   <= FIELD;
                     sep_cnt_q <= 2'd0;
                  end else begin
                     sep_cnt_q <= sep_cnt_q + 2'd1;
                  end
               end
            end
            EOL: begin
               if (out_xfer) begin
                  state_q    <= IDLE;
                  tick_rdy_q <= 1'b1;
                  busy_q     <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               tick_rdy_q <= 1'b1;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   // Count ticks that arrive while a line is in progress, saturating at 255.
   always_ff @(posedge clk) begin
      if (reset) begin
         drops_q <= 8'h00;
      end else if (tick && !tick_rdy_q && (drops_q != 8'hFF)) begin
         drops_q <= drops_q + 8'h01;
      end
   end

   assign tick_rdy = tick_rdy_q;
   assign busy     = busy_q;
   assign cycles   = cycles_q;
   assign drops    = drops_q;

endmodule

// File: tb/tb_trace_line_sched.sv
// Self-checking bench: line-level model of the expected byte stream plus literal spot checks.
module tb_trace_line_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick;
   logic        tick_rdy;
   logic [1:0]  req_val  = '0;
   logic [1:0]  req_rdy;
   logic [15:0] req_char = '0;
   logic [1:0]  req_last = '0;
   logic        out_val;
   logic        out_rdy;
   logic [7:0]  out_char;
   logic [15:0] cycles;
   logic [7:0]  drops;
   logic        busy;

   // Second instance with a single requester, used for the long cycle-counter preload.
   logic        reset2;
   logic        tick2;
   logic        tick_rdy2;
   logic [0:0]  req_rdy2;
   logic [7:0]  char2;
   logic        out_val2;
   logic [7:0]  out_char2;
   logic [15:0] cycles2;
   logic [7:0]  drops2;
   logic        busy2;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  exp_q[$];
   logic [7:0]  rq0[$];
   logic [7:0]  rq1[$];
   logic [15:0] exp_cycles = 16'h0000;
   int          exp_drops  = 0;
   string       pend_f0 = "";
   string       pend_f1 = "";
   string       rec  = "";
   string       rec2 = "";
   bit          rec2_on = 1'b0;
   bit          done2 = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_char = 8'h00;
   bit          m_idle;
   bit          bp = 1'b0;
   logic [3:0]  pat = 4'b1001;
   int          acc;

   always #5 clk = ~clk;

   trace_line_sched #(
      .p_nreqs     (2),
      .p_cnt_nbits (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .tick_rdy (tick_rdy),
      .req_val  (req_val),
      .req_rdy  (req_rdy),
      .req_char (req_char),
      .req_last (req_last),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_char (out_char),
      .cycles   (cycles),
      .drops    (drops),
      .busy     (busy)
   );

   trace_line_sched #(
      .p_nreqs     (1),
      .p_cnt_nbits (16)
   ) dut2 (
      .clk      (clk),
      .reset    (reset2),
      .tick     (tick2),
      .tick_rdy (tick_rdy2),
      .req_val  (1'b1),
      .req_rdy  (req_rdy2),
      .req_char (char2),
      .req_last (1'b1),
      .out_val  (out_val2),
      .out_rdy  (1'b1),
      .out_char (out_char2),
      .cycles   (cycles2),
      .drops    (drops2),
      .busy     (busy2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
      end
   endtask

   function automatic string hex4(input logic [15:0] v);
      string d;
      d = "0123456789abcdef";
      return $sformatf("%c%c%c%c", d[v[15:12]], d[v[11:8]], d[v[7:4]], d[v[3:0]]);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bench-side requesters: present the head of each queue after every clock edge.
   always begin
      @(posedge clk);
      #1;
      req_val[0]     = (rq0.size() > 0);
      req_char[7:0]  = (rq0.size() > 0) ? rq0[0] : 8'h00;
      req_last[0]    = (rq0.size() == 1);
      req_val[1]     = (rq1.size() > 0);
      req_char[15:8] = (rq1.size() > 0) ? rq1[0] : 8'h00;
      req_last[1]    = (rq1.size() == 1);
   end

   // Model and compare: evaluated at the falling edge for the transfer the next rising edge makes.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         exp_q.delete();
         rq0.delete();
         rq1.delete();
         exp_cycles = 16'h0000;
         exp_drops  = 0;
         prev_stall = 1'b0;
      end else begin
         m_idle = (exp_q.size() == 0);
         chk("cycles", cycles, exp_cycles);
         chk("drops", drops, exp_drops);
         chk("busy", busy, !m_idle);
         chk("tick_rdy", tick_rdy, m_idle);
         if (rq0.size() == 0) chk("req_rdy0_unselected", req_rdy[0], 0);
         if (rq0.size() != 0 || rq1.size() == 0) chk("req_rdy1_unselected", req_rdy[1], 0);
         if (prev_stall) begin
            chk("stall_val_held", out_val, 1);
            chk("stall_char_held", out_char, prev_char);
         end
         if (out_val === 1'b1) begin
            if (m_idle) begin
               chk("spurious_out_val", out_val, 0);
            end else begin
               chk("out_char", out_char, exp_q[0]);
               if (out_rdy) begin
                  void'(exp_q.pop_front());
                  rec = $sformatf("%s%c", rec, out_char);
               end
            end
         end
         if (tick) begin
            if (m_idle) begin
               string line;
               line = $sformatf("%s: %s | %s\n", hex4(exp_cycles), pend_f0, pend_f1);
               for (int k = 0; k < line.len(); k++) exp_q.push_back(line[k]);
               exp_cycles = exp_cycles + 16'h0001;
            end else if (exp_drops < 255) begin
               exp_drops++;
            end
         end
         if (req_val[0] && req_rdy[0]) void'(rq0.pop_front());
         if (req_val[1] && req_rdy[1]) void'(rq1.pop_front());
         prev_stall = out_val && !out_rdy;
         prev_char  = out_char;
      end
   end

   // Capture the second instance's stream only around the line of interest.
   always @(negedge clk) begin
      if (rec2_on && !reset2 && out_val2 === 1'b1) rec2 = $sformatf("%s%c", rec2, out_char2);
   end

   task automatic start_line(input string f0, input string f1, input bit e0);
      rec = "";
      pend_f0 = e0 ? "" : f0;
      pend_f1 = f1;
      if (e0) rq0.push_back(8'h00);
      else for (int k = 0; k < f0.len(); k++) rq0.push_back(f0[k]);
      for (int k = 0; k < f1.len(); k++) rq1.push_back(f1[k]);
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 400; k++) begin
         if (bp) out_rdy = pat[k % 4];
         step();
         if (exp_q.size() == 0) break;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL line_timeout: %0d chars still expected, required 0", exp_q.size());
      end
      out_rdy = 1'b1;
      step();
   endtask

   task automatic send_line(input string f0, input string f1, input bit e0);
      start_line(f0, f1, e0);
      wait_idle();
   endtask

   initial begin
      reset   = 1'b1;
      tick    = 1'b0;
      out_rdy = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_cycles", cycles, 0);
      chk("rst_drops", drops, 0);
      chk("rst_out_val", out_val, 0);
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tick_rdy", tick_rdy, 1);

      send_line("ab", "c", 1'b0);
      chk_str("line_basic", rec, "0000: ab | c\n");
      chk("cycles_basic", cycles, 1);

      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      send_line("", "x", 1'b1);
      chk_str("line_empty_field", rec, "0000:  | x\n");

      bp = 1'b1;
      send_line("wxyz", "q", 1'b0);
      bp = 1'b0;
      chk_str("line_backpressure", rec, "0001: wxyz | q\n");

      start_line("d", "e", 1'b0);
      out_rdy = 1'b0;
      tick    = 1'b1;
      repeat (300) step();
      tick    = 1'b0;
      out_rdy = 1'b1;
      wait_idle();
      chk("drops_saturated", drops, 255);
      chk("cycles_after_drops", cycles, 3);
      chk_str("line_during_drops", rec, "0002: d | e\n");
      send_line("f", "g", 1'b0);
      chk_str("line_after_drops", rec, "0003: f | g\n");
      chk("cycles_after_accept", cycles, 4);

      start_line("pqrstu", "i", 1'b0);
      for (int k = 0; k < 100; k++) begin
         step();
         if (rec.len() >= 8) break;
      end
      chk("mid_field_reached", rec.len() >= 8, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_out_val", out_val, 0);
      chk("midrst_tick_rdy", tick_rdy, 1);
      chk("midrst_cycles", cycles, 0);
      chk("midrst_busy", busy, 0);
      send_line("h", "i", 1'b0);
      chk_str("line_after_reset", rec, "0000: h | i\n");
      chk("cycles_after_reset", cycles, 1);

      for (int k = 0; k < 90000 && !done2; k++) step();
      if (!done2) begin
         n_checks++;
         n_errors++;
         $display("FAIL preload_timeout: done=0, required 1");
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Drive 0x1a3e accepted ticks into the single-requester instance, then check the next line.
   initial begin
      reset2 = 1'b1;
      tick2  = 1'b0;
      char2  = 8'h00;
      repeat (3) step();
      reset2 = 1'b0;
      tick2  = 1'b1;
      acc    = 0;
      for (int k = 0; k < 85000 && acc < 32'h1a3e; k++) begin
         @(negedge clk);
         if (tick_rdy2 === 1'b1) acc++;
      end
      @(posedge clk);
      #1;
      tick2 = 1'b0;
      chk("preload_accepts", acc, 32'h1a3e);
      for (int k = 0; k < 50 && busy2 !== 1'b0; k++) step();
      char2   = 8'h7a;
      rec2_on = 1'b1;
      tick2   = 1'b1;
      step();
      tick2 = 1'b0;
      for (int k = 0; k < 50; k++) begin
         step();
         if (busy2 === 1'b0) break;
      end
      step();
      chk_str("preload_line", rec2, "1a3e: z\n");
      chk("preload_cycles", cycles2, 16'h1a3f);
      done2 = 1'b1;
   end

endmodule
